quadrature_cordic_phase: RTL

//  Downstream consumer of the quadrature multiply-accumulate stage. Converts each
//  (COS sum, SIN sum) pair, delivered once per half-period, into phase and magnitude.

---
 rtl/quadrature_cordic_pkg.sv | 43 ++++
 rtl/quadrature_cordic_phase_if.sv | 27 ++
 rtl/quadrature_cordic_phase.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/quadrature_cordic_pkg.sv
// Shared definitions for the quadrature CORDIC phase/magnitude converter.
//   cordic_state_e : controller states (idle, load, iterate, done)
//   ATAN_TURN32    : atan(2^-i) as a fraction of a turn, scaled to 2^32 per turn
//   atan_lsb()     : the same angle rounded to a chosen phase width
//   CORDIC_GAIN    : vectoring-mode gain left on MAGNITUDE (for software scaling)
package quadrature_cordic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StIter,
        StDone
    } cordic_state_e;

    localparam int unsigned ATAN_TABLE_LEN = 32;

    // round(atan(2^-i) / (2*pi) * 2^32)
    localparam logic [31:0] ATAN_TURN32 [ATAN_TABLE_LEN] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    localparam real CORDIC_GAIN = 1.64676;

    // round(atan(2^-i) / (2*pi) * 2^phase_width), valid for phase_width <= 32
    function automatic logic [31:0] atan_lsb(input int unsigned i,
                                             input int unsigned phase_width);
        logic [63:0] t;
        t = {32'd0, ATAN_TURN32[i[4:0]]};
        if (phase_width >= 32) begin
            return ATAN_TURN32[i[4:0]];
        end
        t = t + (64'd1 << (31 - phase_width));
        return 32'(t >> (32 - phase_width));
    endfunction

endpackage

// File: rtl/quadrature_cordic_phase_if.sv
// Handshake/data bundle between the MAC stage (master) and the CORDIC converter (slave).
//   IN_VALID/IN_SIN/IN_COS          : sample strobe and signed Y/X components (master -> slave)
//   BUSY/DROPPED/OUT_VALID          : converter status and result strobe (slave -> master)
//   PHASE/MAGNITUDE                 : fraction-of-turn angle and gain-scaled magnitude
interface quadrature_cordic_phase_if #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PHASE_WIDTH = 16
);
    logic                          IN_VALID;
    logic signed [DATA_WIDTH-1:0]  IN_SIN;
    logic signed [DATA_WIDTH-1:0]  IN_COS;
    logic                          BUSY;
    logic                          DROPPED;
    logic                          OUT_VALID;
    logic        [PHASE_WIDTH-1:0] PHASE;
    logic        [DATA_WIDTH:0]    MAGNITUDE;

    modport master (
        output IN_VALID, IN_SIN, IN_COS,
        input  BUSY, DROPPED, OUT_VALID, PHASE, MAGNITUDE
    );

    modport slave (
        input  IN_VALID, IN_SIN, IN_COS,
        output BUSY, DROPPED, OUT_VALID, PHASE, MAGNITUDE
    );
endinterface

// File: rtl/quadrature_cordic_phase.sv
// Iterative vectoring-mode CORDIC: converts each (COS, SIN) pair from the MAC stage into
// an unsigned phase (fraction of a turn, 0 = +X axis) and a magnitude scaled by the
// CORDIC gain. One micro-rotation per clock.
//   CLK   : clock
//   RESET : synchronous, active-high; aborts any conversion in progress
//   bus   : slave side of quadrature_cordic_phase_if
//           IN_VALID/IN_SIN/IN_COS in; BUSY/DROPPED/OUT_VALID/PHASE/MAGNITUDE out
module quadrature_cordic_phase
    import quadrature_cordic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned ITERATIONS  = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    quadrature_cordic_phase_if.slave  bus
);

    // Two guard bits: one for negating -2^(DATA_WIDTH-1), one for sqrt2*K growth.
    localparam int unsigned XW = DATA_WIDTH + 2;
    localparam int unsigned IW = $clog2(ITERATIONS);
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERATIONS - 1);
    localparam logic [PHASE_WIDTH-1:0] HALF_TURN = {1'b1, {(PHASE_WIDTH-1){1'b0}}};

    cordic_state_e r_state;
    cordic_state_e w_state_next;

    logic w_busy;
    logic w_capture;
    logic w_drop;

    logic signed [XW-1:0]          r_x;
    logic signed [XW-1:0]          r_y;
    logic        [PHASE_WIDTH-1:0] r_z;
    logic        [IW-1:0]          r_iter;
    logic                          r_zero;
    logic        [PHASE_WIDTH-1:0] r_phase;
    logic        [DATA_WIDTH:0]    r_mag;
    logic                          r_out_valid;
    logic                          r_dropped;

    logic signed [XW-1:0]          w_x_sh;
    logic signed [XW-1:0]          w_y_sh;
    logic signed [XW-1:0]          w_x_step;
    logic signed [XW-1:0]          w_y_step;
    logic        [PHASE_WIDTH-1:0] w_z_step;
    logic        [PHASE_WIDTH-1:0] w_atan;
    logic        [PHASE_WIDTH-1:0] w_atan_rom [ITERATIONS];

    // Per-iteration angle constants at this phase width.
    for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan_rom
        assign w_atan_rom[g] = PHASE_WIDTH'(atan_lsb(g, PHASE_WIDTH));
    end

    // ------------------------------------------------------------------ FSM: state register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------ FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (bus.IN_VALID) w_state_next = StLoad;
            StLoad:  w_state_next = StIter;
            StIter:  if (r_iter == LAST_ITER) w_state_next = StDone;
            // DONE accepts a new sample so back-to-back conversions lose no cycle.
            StDone:  w_state_next = bus.IN_VALID ? StLoad : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // ------------------------------------------------------------------ FSM: outputs
    always_comb begin
        w_busy    = 1'b0;
        w_capture = 1'b0;
        w_drop    = 1'b0;
        unique case (r_state)
            StIdle, StDone: w_capture = bus.IN_VALID;
            StLoad, StIter: begin
                w_busy = 1'b1;
                w_drop = bus.IN_VALID;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ micro-rotation
    assign w_x_sh = r_x >>> r_iter;
    assign w_y_sh = r_y >>> r_iter;
    assign w_atan = w_atan_rom[r_iter];

    // Rotate toward the +X axis; both updates use the pre-step x and y.
    always_comb begin
        if (r_y[XW-1]) begin
            w_x_step = r_x - w_y_sh;
            w_y_step = r_y + w_x_sh;
            w_z_step = r_z - w_atan;
        end else begin
            w_x_step = r_x + w_y_sh;
            w_y_step = r_y - w_x_sh;
            w_z_step = r_z + w_atan;
        end
    end

    // ------------------------------------------------------------------ datapath
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x         <= '0;
            r_y         <= '0;
            r_z         <= '0;
            r_iter      <= '0;
            r_zero      <= 1'b0;
            r_phase     <= '0;
            r_mag       <= '0;
            r_out_valid <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_dropped   <= w_drop;

            unique case (r_state)
                StLoad: begin
                    // Fold the left half-plane onto the right; CORDIC only converges
                    // for |angle| < ~99.9 degrees.
                    if (r_x[XW-1]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= HALF_TURN;
                    end else begin
                        r_z <= '0;
                    end
                    r_iter <= '0;
                end
                StIter: begin
                    r_x    <= w_x_step;
                    r_y    <= w_y_step;
                    r_z    <= w_z_step;
                    r_iter <= r_iter + IW'(1);
                end
                StDone: begin
                    // atan2(0,0) is undefined; report a clean zero instead of the
                    // sum of rotation angles the iterations would leave in z.
                    r_phase     <= r_zero ? '0 : r_z;
                    r_mag       <= r_zero ? '0 : r_x[DATA_WIDTH:0];
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase

            // Capture lands after the DONE outputs read the old x/z (non-blocking).
            if (w_capture) begin
                r_x    <= {{2{bus.IN_COS[DATA_WIDTH-1]}}, bus.IN_COS};
                r_y    <= {{2{bus.IN_SIN[DATA_WIDTH-1]}}, bus.IN_SIN};
                r_zero <= (bus.IN_COS == '0) && (bus.IN_SIN == '0);
            end
        end
    end

    assign bus.BUSY      = w_busy;
    assign bus.DROPPED   = r_dropped;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.PHASE     = r_phase;
    assign bus.MAGNITUDE = r_mag;

endmodule
